// File: rtl/n_reg_serializer.sv
// Parallel-in/serial-out reader for an N-bit register word: captures D on an
// accepted Load and shifts it out one bit per CLOCK, with stall and zero-gap chaining.
module n_reg_serializer #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         CLOCK,
  input  logic         nClear,
  input  logic         Load,
  input  logic [N-1:0] D,
  input  logic         Stall,
  output logic         Ready,
  output logic         SerOut,
  output logic         SerValid,
  output logic         Last
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t         state_r, state_nxt_s;
  logic [N-1:0]   sr_r, sr_nxt_s, sr_shift_s;
  logic [CW-1:0]  cnt_r, cnt_nxt_s;
  logic           accept_s;

  // Output decode from registered state; Stall reaches only Ready.
  always_comb begin
    SerValid = (state_r == SHIFT);
    Last     = SerValid && (cnt_r == CNT_ZERO);
    Ready    = !SerValid || (Last && !Stall);
    if (MSB_FIRST) begin
      SerOut = SerValid && sr_r[N-1];
    end else begin
      SerOut = SerValid && sr_r[0];
    end
  end

  // Shift toward the output end, zero-filling the vacated bit.
  always_comb begin
    if (MSB_FIRST) begin
      sr_shift_s = {sr_r[N-2:0], 1'b0};
    end else begin
      sr_shift_s = {1'b0, sr_r[N-1:1]};
    end
  end

  assign accept_s = Load && Ready;

  // Next-state logic: hold by default, accept/shift/finish per state.
  always_comb begin
    state_nxt_s = state_r;
    sr_nxt_s    = sr_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = SHIFT;
          sr_nxt_s    = D;
          cnt_nxt_s   = CNT_MAX;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (Stall) begin
          state_nxt_s = SHIFT;
        end else if (cnt_r != CNT_ZERO) begin
          sr_nxt_s  = sr_shift_s;
          cnt_nxt_s = cnt_r - CNT_ONE;
        end else if (accept_s) begin
          // Chain the next word with no idle gap.
          sr_nxt_s  = D;
          cnt_nxt_s = CNT_MAX;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        sr_nxt_s    = {N{1'b0}};
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // State register with asynchronous clear.
  always_ff @(posedge CLOCK or negedge nClear) begin
    if (!nClear) begin
      state_r <= IDLE;
      sr_r    <= {N{1'b0}};
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      sr_r    <= sr_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_n_reg_serializer.sv
// Bench for n_reg_serializer: an 8-bit MSB-first and a 16-bit LSB-first instance
// share Load/Stall and are compared every cycle against per-word bit queues.
module tb_n_reg_serializer;

  logic        clk;
  logic        nclear;
  logic        load;
  logic        stall;
  logic [7:0]  d8;
  logic [15:0] d16;
  logic        rdy8, so8, sv8, last8;
  logic        rdy16, so16, sv16, last16;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference: the bits still owed for the word in flight, front = on SerOut now.
  bit q8[$];
  bit q16[$];

  n_reg_serializer #(.N(8), .MSB_FIRST(1'b1)) dut8 (
    .CLOCK(clk), .nClear(nclear), .Load(load), .D(d8), .Stall(stall),
    .Ready(rdy8), .SerOut(so8), .SerValid(sv8), .Last(last8)
  );

  n_reg_serializer #(.N(16), .MSB_FIRST(1'b0)) dut16 (
    .CLOCK(clk), .nClear(nclear), .Load(load), .D(d16), .Stall(stall),
    .Ready(rdy16), .SerOut(so16), .SerValid(sv16), .Last(last16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Drive one cycle's inputs, check all outputs, then advance the model at the edge.
  task automatic cycle(input bit ld, input logic [7:0] w8, input logic [15:0] w16, input bit st);
    bit v8, l8, r8, o8, v16, l16, r16, o16;
    @(negedge clk);
    load = ld; d8 = w8; d16 = w16; stall = st;
    #1;
    v8  = (q8.size() > 0);   l8  = (q8.size() == 1);
    o8  = v8 ? q8[0] : 1'b0; r8  = !v8 || (l8 && !st);
    v16 = (q16.size() > 0);  l16 = (q16.size() == 1);
    o16 = v16 ? q16[0] : 1'b0; r16 = !v16 || (l16 && !st);
    check_eq("ser8_valid", 32'(sv8), 32'(v8));
    check_eq("ser8_out",   32'(so8), 32'(o8));
    check_eq("ser8_last",  32'(last8), 32'(l8));
    check_eq("ser8_ready", 32'(rdy8), 32'(r8));
    check_eq("ser16_valid", 32'(sv16), 32'(v16));
    check_eq("ser16_out",   32'(so16), 32'(o16));
    check_eq("ser16_last",  32'(last16), 32'(l16));
    check_eq("ser16_ready", 32'(rdy16), 32'(r16));
    @(posedge clk);
    if (v8 && !st) void'(q8.pop_front());
    if (ld && r8) begin
      q8 = {};
      for (int i = 7; i >= 0; i--) q8.push_back(w8[i]);
    end
    if (v16 && !st) void'(q16.pop_front());
    if (ld && r16) begin
      q16 = {};
      for (int i = 0; i < 16; i++) q16.push_back(w16[i]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 16'h0000, 1'b0);
  endtask

  // Short asynchronous clear between edges; outputs must drop without a clock.
  task automatic clear_pulse();
    @(negedge clk);
    load = 1'b0; stall = 1'b0;
    #2 nclear = 1'b0;
    #1;
    check_eq("rst8_valid", 32'(sv8), 32'd0);
    check_eq("rst8_out",   32'(so8), 32'd0);
    check_eq("rst8_last",  32'(last8), 32'd0);
    check_eq("rst8_ready", 32'(rdy8), 32'd1);
    check_eq("rst16_valid", 32'(sv16), 32'd0);
    check_eq("rst16_ready", 32'(rdy16), 32'd1);
    nclear = 1'b1;
    q8 = {};
    q16 = {};
  endtask

  initial begin
    nclear = 1'b0; load = 1'b1; stall = 1'b0; d8 = 8'hFF; d16 = 16'hFFFF;
    #1;
    check_eq("reset_valid", 32'(sv8), 32'd0);
    check_eq("reset_out",   32'(so8), 32'd0);
    check_eq("reset_last",  32'(last8), 32'd0);
    check_eq("reset_ready", 32'(rdy8), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_hold_valid", 32'(sv8), 32'd0);
    @(negedge clk);
    load = 1'b0;
    nclear = 1'b1;

    // Single word: 0F MSB-first, F0F0 LSB-first.
    cycle(1'b1, 8'h0F, 16'hF0F0, 1'b0);
    idle(18);

    // Back-to-back: hold Load with 09 through the Last cycle of 0F.
    cycle(1'b1, 8'h0F, 16'h1234, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'h09, 16'h5678, 1'b0);
    idle(20);

    // Load while not ready is dropped.
    cycle(1'b1, 8'h0F, 16'hA5A5, 1'b0);
    idle(3);
    cycle(1'b1, 8'hFF, 16'hFFFF, 1'b0);
    idle(20);

    // Three stalled cycles on bit 4, then stall with Load on the last bit.
    cycle(1'b1, 8'h0F, 16'h00FF, 1'b0);
    idle(3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 16'h0000, 1'b1);
    idle(20);
    cycle(1'b1, 8'h0F, 16'h0F0F, 1'b0);
    idle(7);
    for (int i = 0; i < 2; i++) cycle(1'b1, 8'hAA, 16'h3333, 1'b1);
    cycle(1'b1, 8'hAA, 16'h3333, 1'b0);
    idle(20);

    // Stall in IDLE does not block a Load.
    cycle(1'b1, 8'h81, 16'h8001, 1'b1);
    idle(20);

    // Mid-word asynchronous clear, then a fresh word.
    cycle(1'b1, 8'hA5, 16'hC3C3, 1'b0);
    idle(2);
    clear_pulse();
    cycle(1'b1, 8'h3C, 16'h3C3C, 1'b0);
    idle(20);

    // Randomized traffic with changing D, stalls and held/dropped Loads.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 3) != 0), 8'($urandom), 16'($urandom),
            ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 499) == 0) clear_pulse();
    end
    idle(20);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
